// File: rtl/fifo_reader_if.sv
// Byte stream carried from the FIFO read controller to its consumer.
// The master drives data/valid; the slave answers with ready.
interface fifo_reader_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_reader.sv
// Read-side controller for the 16x8 synchronous FIFO: issues read strobes,
// captures the registered read data and streams it through a 4-entry buffer.
module fifo_reader #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic             fifo_wr,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd,
  fifo_reader_if.master    m,
  output logic [CNT_W-1:0] rd_count
);
  localparam int DATA_W = 8;

  logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
  logic [1:0]        head;
  logic [1:0]        tail;
  logic [2:0]        occ;
  logic              inflight;
  logic [2:0]        pending;
  logic              can_issue;
  logic              accepted;
  logic              pop;

  // Bytes already owned: buffered plus the one arriving on fifo_dout next cycle.
  assign pending   = occ + {2'b00, inflight};
  assign can_issue = enable && (pending <= 3'(BUF_DEPTH - 1));
  assign fifo_rd   = rst_n && can_issue && !fifo_empty;
  // The FIFO lets a successful write win over a read in the same cycle.
  assign accepted  = fifo_rd && !(fifo_wr && !fifo_full);

  assign m.m_valid = (occ != 3'd0);
  assign m.m_data  = buf_mem[head];
  assign pop       = m.m_valid && m.m_ready;

  // Capture stage: fifo_dout is valid exactly one cycle after an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
      head     <= 2'd0;
      tail     <= 2'd0;
      occ      <= 3'd0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= accepted;
      if (inflight) begin
        buf_mem[tail] <= fifo_dout;
        tail          <= tail + 2'd1;
      end
      if (pop) begin
        head     <= head + 2'd1;
        rd_count <= rd_count + CNT_W'(1);
      end
      case ({inflight, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
      assert (!(inflight && occ == 3'(BUF_DEPTH)));
    end
  end
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural 16-deep FIFO with write priority,
// scoreboard of written bytes, and a monitor checking the delivered stream.
module tb_fifo_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_dout;
  logic [7:0]  wr_data;
  logic        fifo_rd;
  logic [15:0] rd_count;

  int          total;
  int          bad;
  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  int          bd_left;
  logic [7:0]  bdb;
  logic        wr_ok;
  logic        rd_ok;
  logic [15:0] cnt_ref;
  int          nhs;
  logic        prev_hold;
  logic [7:0]  prev_data;
  int          reads;
  int          coll;
  int          wrs;
  int          base;
  logic [7:0]  nxt;

  fifo_reader_if bus ();

  fifo_reader #(.BUF_DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .m          (bus),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    fifo_wr = 1'b1;
    wr_data = d;
    tick();
    fifo_wr = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    fifo_wr     = 1'b0;
    wr_data     = 8'h00;
    bus.m_ready = 1'b0;
    fifo_empty  = 1'b1;
    fifo_full   = 1'b0;
    fifo_dout   = 8'h00;
    bd_left     = 0;
    total       = 0;
    bad         = 0;
    cnt_ref     = 16'd0;
    nhs         = 0;
    prev_hold   = 1'b0;
    prev_data   = 8'h00;

    fork
      // FIFO model: write beats read when not full; read data is registered.
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          fq.delete();
          exp_q.delete();
          fifo_dout  <= 8'h00;
          fifo_empty <= 1'b1;
          fifo_full  <= 1'b0;
        end else begin
          wr_ok = fifo_wr && (fq.size() < 16);
          rd_ok = fifo_rd && !wr_ok && (fq.size() > 0);
          if (rd_ok) fifo_dout <= fq.pop_front();
          if (wr_ok) begin
            fq.push_back(wr_data);
            exp_q.push_back(wr_data);
          end
          if (bd_left > 0 && fq.size() < 16) begin
            bdb = 8'($urandom);
            fq.push_back(bdb);
            exp_q.push_back(bdb);
            bd_left--;
          end
          fifo_empty <= (fq.size() == 0);
          fifo_full  <= (fq.size() == 16);
        end
      end
      // Stream monitor: order, count and hold-while-stalled checks.
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          cnt_ref   = 16'd0;
          prev_hold = 1'b0;
        end else begin
          if (prev_hold) begin
            chk("hold_valid", int'(bus.m_valid), 1);
            chk("hold_data", int'(bus.m_data), int'(prev_data));
          end
          if (bus.m_valid && bus.m_ready) begin
            chk("rd_count_stream", int'(rd_count), int'(cnt_ref));
            chk("byte_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("data_order", int'(bus.m_data), int'(exp_q.pop_front()));
            cnt_ref++;
            nhs++;
          end
          prev_hold = bus.m_valid && !bus.m_ready;
          prev_data = bus.m_data;
        end
      end
    join_none

    // Reset state
    tick();
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_fifo_rd", int'(fifo_rd), 0);
    chk("rst_rd_count", int'(rd_count), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    rst_n = 1'b1;
    tick();

    // Preload 10..17 then drain at full rate
    for (int i = 0; i < 8; i++) wr_byte(8'(8'h10 + i));
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("t1_first_rd", int'(fifo_rd), 1);
    chk("t1_valid_n0", int'(bus.m_valid), 0);
    @(negedge clk);
    chk("t1_valid_n1", int'(bus.m_valid), 0);
    @(negedge clk);
    chk("t1_valid_n2", int'(bus.m_valid), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t1_back_to_back", int'(bus.m_valid), 1);
    end
    @(negedge clk);
    chk("t1_valid_end", int'(bus.m_valid), 0);
    chk("t1_rd_count", int'(rd_count), 8);
    chk("t1_fifo_empty", int'(fifo_empty), 1);

    // Back-pressure: 6 bytes, consumer stalled
    tick();
    enable      = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr_byte(8'(8'h20 + i));
    enable = 1'b1;
    reads  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fifo_rd && !fifo_wr) reads++;
    end
    chk("t2_reads", reads, 4);
    chk("t2_fifo_left", fq.size(), 2);
    chk("t2_valid", int'(bus.m_valid), 1);
    chk("t2_head", int'(bus.m_data), 8'h20);
    tick();
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("t2_rd_still_blocked", int'(fifo_rd), 0);
    @(negedge clk);
    chk("t2_rd_resume", int'(fifo_rd), 1);
    repeat (12) @(negedge clk);
    chk("t2_drained_valid", int'(bus.m_valid), 0);
    chk("t2_rd_count", int'(rd_count), 14);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Writer colliding with reads every other cycle
    tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) wr_byte(8'(8'h30 + i));
    enable = 1'b1;
    nxt    = 8'h34;
    wrs    = 0;
    coll   = 0;
    for (int i = 0; i < 24; i++) begin
      fifo_wr = (i % 2 == 0) && !fifo_empty && !fifo_full;
      wr_data = nxt;
      if (fifo_wr) begin
        nxt++;
        wrs++;
      end
      @(negedge clk);
      if (fifo_rd && fifo_wr && !fifo_full) coll++;
      tick();
    end
    fifo_wr = 1'b0;
    repeat (16) @(negedge clk);
    chk("t3_collisions_seen", int'(coll > 0), 1);
    chk("t3_sb_empty", exp_q.size(), 0);
    chk("t3_rd_count", int'(rd_count), 14 + 4 + wrs);
    chk("t3_valid_end", int'(bus.m_valid), 0);

    // Enable dropped right after an accepted read
    tick();
    base   = int'(rd_count);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) wr_byte(8'(8'h40 + i));
    enable = 1'b1;
    @(negedge clk);
    chk("t4_rd_issued", int'(fifo_rd), 1);
    tick();
    enable = 1'b0;
    reads  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_rd) reads++;
    end
    chk("t4_no_more_rd", reads, 0);
    chk("t4_one_delivered", int'(rd_count), base + 1);
    chk("t4_fifo_left", fq.size(), 2);
    tick();
    enable = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_resume_count", int'(rd_count), base + 3);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Asynchronous reset with occ=3, inflight=1
    tick();
    enable      = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr_byte(8'(8'h50 + i));
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    chk("t5_pre_valid", int'(bus.m_valid), 1);
    chk("t5_pre_count", int'(rd_count), base + 3);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", int'(bus.m_valid), 0);
    chk("t5_async_rd", int'(fifo_rd), 0);
    chk("t5_async_count", int'(rd_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    wr_byte(8'hA5);
    repeat (8) @(negedge clk);
    chk("t5_single_count", int'(rd_count), 1);
    chk("t5_single_valid", int'(bus.m_valid), 0);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Long random run: 65537 bytes, rd_count wraps to 1
    tick();
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    enable  = 1'b1;
    nhs     = 0;
    bd_left = 65537;
    for (int c = 0; c < 80000 && nhs < 65537; c++) begin
      tick();
      bus.m_ready = ($urandom_range(31) != 0);
    end
    bus.m_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_handshakes", nhs, 65537);
    chk("t6_rd_count_wrap", int'(rd_count), 1);
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_valid_end", int'(bus.m_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
